// File: rtl/loom_axi_burst_master_if.sv
// loom_axi_burst_master_if
//   Bundles every bus of the command-driven AXI4 burst master:
//     cmd_*        command request (write flag, start byte address, beat count)
//     wdata*       write data stream in
//     rdata*       read data stream out
//     sts_*, busy  completion status and activity flag
//     m_axi_*      AXI4 full master channels (AW, W, B, AR, R)
//   modport master : the burst engine's view
//   modport slave  : the environment's view (command source, data endpoints, AXI slave)
interface loom_axi_burst_master_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int LEN_WIDTH  = 16
);
  // command / status
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [LEN_WIDTH-1:0]    cmd_beats;
  logic                    sts_valid;
  logic                    sts_err;
  logic                    busy;
  // data streams
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    wdata_valid;
  logic                    wdata_ready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rdata_valid;
  logic                    rdata_ready;
  // AW
  logic [ID_WIDTH-1:0]     m_axi_awid;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  // W
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  // B
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  // AR
  logic [ID_WIDTH-1:0]     m_axi_arid;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  // R
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_beats,
    output cmd_ready, sts_valid, sts_err, busy,
    input  wdata, wdata_valid, rdata_ready,
    output wdata_ready, rdata, rdata_valid,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_beats,
    input  cmd_ready, sts_valid, sts_err, busy,
    output wdata, wdata_valid, rdata_ready,
    input  wdata_ready, rdata, rdata_valid,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/loom_axi_burst_master.sv
// loom_axi_burst_master
//   Command-driven AXI4 full master. Each accepted command (read or write,
//   start address, beat count) is executed as a sequence of INCR bursts, split
//   at MAX_BURST beats and at 4 KiB boundaries, with one burst outstanding.
//   Write data is passed straight from the wdata stream onto W; read data is
//   passed straight from R onto the rdata stream. A one-cycle sts pulse with an
//   accumulated error flag closes every command.
// Ports
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : loom_axi_burst_master_if.master (command, data streams, status, AXI4)
module loom_axi_burst_master #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0,
  parameter int MAX_BURST  = 256,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  loom_axi_burst_master_if.master       bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  // common width for comparing beat counts of different origins
  localparam int CW    = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_ADDR, S_WDATA, S_BWAIT, S_RDATA, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  is_write;
  logic                  err;
  logic [8:0]            burst;      // beats in current burst, 1..256
  logic [8:0]            beat;       // beat index within current burst
  logic [8:0]            burst_calc;
  logic [8:0]            len_full;
  logic [12:0]           room_bytes;
  logic [12:0]           room_beats;
  logic                  last_beat;
  logic                  more;
  logic                  w_fire;
  logic                  r_fire;
  logic [CW-1:0]         lim;

  // beats left before the next 4 KiB boundary (addr is always beat aligned)
  assign room_bytes = 13'h1000 - {1'b0, addr[11:0]};
  assign room_beats = room_bytes >> SZ;

  always_comb begin
    lim = CW'(MAX_BURST);
    if (CW'(room_beats) < lim) lim = CW'(room_beats);
    if (CW'(remaining) < lim)  lim = CW'(remaining);
    burst_calc = lim[8:0];
  end

  assign len_full  = burst - 9'd1;
  assign last_beat = (beat == len_full);
  // another burst follows unless this one drains the command
  assign more      = (CW'(remaining) != CW'(burst));
  assign w_fire    = (state == S_WDATA) && bus.wdata_valid && bus.m_axi_wready;
  assign r_fire    = (state == S_RDATA) && bus.m_axi_rvalid && bus.rdata_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next state and outputs
  always_comb begin
    state_nxt          = state;
    bus.cmd_ready      = (state == S_IDLE) && !rst;
    bus.busy           = (state != S_IDLE);
    bus.sts_valid      = (state == S_DONE);
    bus.sts_err        = (state == S_DONE) && err;

    bus.m_axi_awid     = ID_WIDTH'(AXI_ID);
    bus.m_axi_awaddr   = addr;
    bus.m_axi_awlen    = len_full[7:0];
    bus.m_axi_awsize   = 3'(SZ);
    bus.m_axi_awburst  = 2'b01;
    bus.m_axi_awvalid  = (state == S_ADDR) && is_write;

    bus.m_axi_wdata    = bus.wdata;
    bus.m_axi_wstrb    = '1;
    bus.m_axi_wlast    = (state == S_WDATA) && last_beat;
    bus.m_axi_wvalid   = (state == S_WDATA) && bus.wdata_valid;
    bus.wdata_ready    = (state == S_WDATA) && bus.m_axi_wready;

    bus.m_axi_bready   = (state == S_BWAIT);

    bus.m_axi_arid     = ID_WIDTH'(AXI_ID);
    bus.m_axi_araddr   = addr;
    bus.m_axi_arlen    = len_full[7:0];
    bus.m_axi_arsize   = 3'(SZ);
    bus.m_axi_arburst  = 2'b01;
    bus.m_axi_arvalid  = (state == S_ADDR) && !is_write;

    bus.rdata          = bus.m_axi_rdata;
    bus.rdata_valid    = (state == S_RDATA) && bus.m_axi_rvalid;
    bus.m_axi_rready   = (state == S_RDATA) && bus.rdata_ready;

    unique case (state)
      S_IDLE:  if (bus.cmd_valid) state_nxt = S_PREP;
      // burst length is registered here so ADDR drives a stable payload
      S_PREP:  state_nxt = (remaining == '0) ? S_DONE : S_ADDR;
      S_ADDR: begin
        if (is_write && bus.m_axi_awready)       state_nxt = S_WDATA;
        else if (!is_write && bus.m_axi_arready) state_nxt = S_RDATA;
      end
      S_WDATA: if (w_fire && last_beat) state_nxt = S_BWAIT;
      S_BWAIT: if (bus.m_axi_bvalid) state_nxt = more ? S_PREP : S_DONE;
      // read burst closes on the counted final beat, whatever rlast says
      S_RDATA: if (r_fire && last_beat) state_nxt = more ? S_PREP : S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // command datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      is_write  <= 1'b0;
      err       <= 1'b0;
      burst     <= '0;
      beat      <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.cmd_valid) begin
          // unaligned start is forced down to a beat boundary and flagged
          addr      <= bus.cmd_addr & ~LOW_MASK;
          remaining <= bus.cmd_beats;
          is_write  <= bus.cmd_write;
          err       <= |bus.cmd_addr[SZ-1:0];
        end
        S_PREP: begin
          burst <= burst_calc;
          beat  <= '0;
        end
        S_WDATA: if (w_fire) beat <= beat + 9'd1;
        S_BWAIT: if (bus.m_axi_bvalid) begin
          if (bus.m_axi_bresp != 2'b00) err <= 1'b1;
          addr      <= addr + (ADDR_WIDTH'(burst) << SZ);
          remaining <= remaining - LEN_WIDTH'(burst);
        end
        S_RDATA: if (r_fire) begin
          beat <= beat + 9'd1;
          if (bus.m_axi_rresp != 2'b00 || bus.m_axi_rlast != last_beat) err <= 1'b1;
          if (last_beat) begin
            addr      <= addr + (ADDR_WIDTH'(burst) << SZ);
            remaining <= remaining - LEN_WIDTH'(burst);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_loom_axi_burst_master.sv
// Bench for loom_axi_burst_master: an AXI slave with stall injection, a write
// data source and a read sink run every cycle in the background; the main flow
// issues commands and checks them against a command-level reference model
// (expected burst list, contiguous beat addresses, data pattern, error flag).
module tb_loom_axi_burst_master;
  localparam int AW = 64, DW = 128, IW = 4, LW = 16, MB = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  loom_axi_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) bus ();

  loom_axi_burst_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(0), .MAX_BURST(MB), .LEN_WIDTH(LW)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [63:0] a);
    return {a ^ 64'h5a5a_0f0f_3c3c_9696, a};
  endfunction

  int stall_pct = 0;
  function automatic bit go();
    return $urandom_range(99) >= stall_pct;
  endfunction

  // observation state
  typedef struct packed {
    logic [63:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] bt; logic [3:0] id;
  } ax_t;
  ax_t            ax_q[$];
  logic [127:0]   wq[$];
  logic [127:0]   sent[$];
  logic [127:0]   rd_obs[$];
  logic [127:0]   mem[logic [63:0]];
  logic [63:0]    exp_a[$];
  int             exp_l[$];
  int cyc = 0, fire_cyc = 0, first_av = -1, sts_cnt = 0, sts_cyc = 0;
  int w_cnt = 0, wlast_bad = 0, wbad = 0, ovl_bad = 0;
  logic sts_err_v = 1'b0;

  // slave state
  bit          w_act = 0, b_pend = 0, r_act = 0;
  logic [63:0] w_addr = '0, r_addr = '0;
  logic [1:0]  b_resp = 2'b00;
  int w_len = 0, w_idx = 0, r_len = 0, r_idx = 0, r_gbeat = 0, b_dly = 0, burst_no = 0;
  int inj_rresp = -1, inj_rlast = -1, inj_bresp = -1;

  task automatic idle_inputs();
    bus.wdata_valid = 0; bus.wdata = '0; bus.rdata_ready = 0;
    bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_arready = 0;
    bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
    bus.m_axi_rvalid = 0; bus.m_axi_rdata = '0; bus.m_axi_rresp = 0; bus.m_axi_rlast = 0;
  endtask

  // background: drive on negedge, observe the coming posedge's handshakes at +1
  initial begin
    idle_inputs();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        w_act = 0; b_pend = 0; r_act = 0; wq.delete();
        idle_inputs();
      end else begin
        bus.wdata_valid = (wq.size() > 0) && go();
        if (wq.size() > 0) bus.wdata = wq[0]; else bus.wdata = '0;
        bus.m_axi_awready = go();
        bus.m_axi_arready = go();
        bus.m_axi_wready  = go();
        bus.m_axi_bvalid  = b_pend && (b_dly == 0);
        bus.m_axi_bresp   = b_resp;
        bus.m_axi_rvalid  = r_act && go();
        bus.m_axi_rdata   = pat(r_addr + 64'(r_idx) * 64'd16);
        bus.m_axi_rresp   = (r_gbeat == inj_rresp) ? 2'b10 : 2'b00;
        bus.m_axi_rlast   = (r_idx == r_len) ^ (r_gbeat == inj_rlast);
        bus.rdata_ready   = go();
        #1;
        if (bus.m_axi_awvalid || bus.m_axi_arvalid) begin
          if (first_av < 0) first_av = cyc;
          if (w_act || b_pend || r_act) ovl_bad++;
        end
        if (bus.m_axi_awvalid && bus.m_axi_awready) begin
          ax_q.push_back({bus.m_axi_awaddr, bus.m_axi_awlen, bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_awid});
          w_act = 1; w_addr = bus.m_axi_awaddr; w_len = int'(bus.m_axi_awlen); w_idx = 0;
        end
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          if (!w_act || bus.m_axi_wstrb != '1) wbad++;
          else begin
            if (bus.m_axi_wlast != (w_idx == w_len)) wlast_bad++;
            mem[w_addr + 64'(w_idx) * 64'd16] = bus.m_axi_wdata;
            w_cnt++;
            if (w_idx == w_len) begin
              w_act = 0; b_pend = 1; b_dly = $urandom_range(2);
              b_resp = (burst_no == inj_bresp) ? 2'b10 : 2'b00;
              burst_no++;
            end
            w_idx++;
          end
        end
        if (bus.wdata_valid && bus.wdata_ready && wq.size() > 0) void'(wq.pop_front());
        if (bus.m_axi_bvalid && bus.m_axi_bready) b_pend = 0;
        else if (b_pend && b_dly > 0) b_dly--;
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
          ax_q.push_back({bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize, bus.m_axi_arburst, bus.m_axi_arid});
          r_act = 1; r_addr = bus.m_axi_araddr; r_len = int'(bus.m_axi_arlen); r_idx = 0;
        end
        if (bus.m_axi_rvalid && bus.m_axi_rready) begin
          r_idx++; r_gbeat++;
          if (r_idx > r_len) r_act = 0;
        end
        if (bus.rdata_valid && bus.rdata_ready) rd_obs.push_back(bus.rdata);
        if (bus.sts_valid) begin sts_cnt++; sts_err_v = bus.sts_err; sts_cyc = cyc; end
      end
    end
  end

  // reference: bursts a command must produce, from the splitting rules
  task automatic model_bursts(input logic [63:0] a0, input int beats);
    logic [63:0] a;
    int rem, n, room;
    a = a0; rem = beats;
    exp_a.delete(); exp_l.delete();
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 16;
      n = (rem < MB) ? rem : MB;
      if (room < n) n = room;
      exp_a.push_back(a); exp_l.push_back(n - 1);
      a = a + 64'(n * 16);
      rem -= n;
    end
  endtask

  task automatic start_cmd(input bit wr, input logic [63:0] a, input int beats);
    logic [127:0] d;
    bit fired;
    @(negedge clk);
    mem.delete(); rd_obs.delete(); ax_q.delete(); sent.delete(); wq.delete();
    w_cnt = 0; wlast_bad = 0; wbad = 0; ovl_bad = 0; sts_cnt = 0; first_av = -1;
    r_gbeat = 0; burst_no = 0;
    for (int i = 0; i < beats; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      sent.push_back(d);
      if (wr) wq.push_back(d);
    end
    model_bursts(a & ~64'hF, beats);
    bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_beats = LW'(beats);
    fired = 0;
    for (int k = 0; k < 100 && !fired; k++) begin
      #1;
      if (bus.cmd_ready) begin fired = 1; fire_cyc = cyc; end
      else @(negedge clk);
    end
    chk("cmd_hs", fired, 1);
    @(negedge clk);
    bus.cmd_valid = 0;
    #1 chk("busy", bus.busy, 1);
  endtask

  task automatic finish_cmd(input bit wr, input logic [63:0] a, input int beats, input bit xerr);
    bit ok;
    int bad, attr_bad, n;
    logic [63:0] a0;
    a0 = a & ~64'hF;
    ok = 0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk); #1;
      if (sts_cnt > 0) ok = 1;
    end
    chk("sts_seen", ok, 1);
    repeat (3) @(negedge clk);
    #2;
    chk("sts_once", sts_cnt, 1);
    chk("sts_err", sts_err_v, (a[3:0] != 0) || xerr);
    chk("nburst", ax_q.size(), exp_a.size());
    n = (ax_q.size() < exp_a.size()) ? ax_q.size() : exp_a.size();
    attr_bad = 0;
    for (int i = 0; i < n; i++) begin
      chk("ax_addr", ax_q[i].addr, exp_a[i]);
      chk("ax_len", ax_q[i].len, exp_l[i]);
      if (ax_q[i].size != 3'd4 || ax_q[i].bt != 2'b01 || ax_q[i].id != 4'd0) attr_bad++;
    end
    chk("ax_attr", attr_bad, 0);
    bad = 0;
    if (wr) begin
      chk("w_cnt", w_cnt, beats);
      chk("wlast", wlast_bad, 0);
      for (int i = 0; i < beats; i++) begin
        logic [63:0] k;
        k = a0 + 64'(i) * 64'd16;
        if (!mem.exists(k)) bad++;
        else if (mem[k] !== sent[i]) bad++;
      end
      chk("wdata", bad, 0);
    end else begin
      chk("r_cnt", rd_obs.size(), beats);
      for (int i = 0; i < beats && i < rd_obs.size(); i++)
        if (rd_obs[i] !== pat(a0 + 64'(i) * 64'd16)) bad++;
      chk("rdata", bad, 0);
    end
    chk("one_outstanding", ovl_bad, 0);
    chk("w_protocol", wbad, 0);
    if (beats > 0) chk("lat", first_av - fire_cyc, 2);
    else begin
      chk("lat0", sts_cyc - fire_cyc, 2);
      chk("no_axi", first_av, -1);
    end
    chk("back_idle", bus.cmd_ready, 1);
  endtask

  task automatic run_cmd(input bit wr, input logic [63:0] a, input int beats, input bit xerr);
    start_cmd(wr, a, beats);
    finish_cmd(wr, a, beats, xerr);
  endtask

  initial begin
    bit hit;
    int s0;
    logic [63:0] ra;
    rst = 1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_beats = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_outs", {bus.cmd_ready, bus.wdata_ready, bus.rdata_valid, bus.sts_valid, bus.busy,
                     bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready, bus.m_axi_arvalid,
                     bus.m_axi_rready}, 0);
    rst = 0;
    #1 chk("rst_release_ready", bus.cmd_ready, 1);

    stall_pct = 0;
    run_cmd(1, 64'h1000, 4, 0);
    run_cmd(0, 64'hFF0, 3, 0);
    run_cmd(1, 64'h0, 600, 0);
    inj_rresp = 1; run_cmd(0, 64'h2000, 4, 1); inj_rresp = -1;
    run_cmd(1, 64'h7000, 0, 0);

    stall_pct = 40;
    run_cmd(1, 64'h10000, 64, 0);
    run_cmd(0, 64'h20000, 64, 0);
    inj_bresp = 0; run_cmd(1, 64'h3000, 20, 1); inj_bresp = -1;
    inj_rlast = 4; run_cmd(0, 64'h4000, 5, 1); inj_rlast = -1;
    inj_rlast = 1; run_cmd(0, 64'h4800, 5, 1); inj_rlast = -1;
    run_cmd(1, 64'h5008, 3, 0);
    run_cmd(0, 64'hFFFF_FFFF_FFFF_FFC0, 8, 0);
    run_cmd(0, 64'h100, 300, 0);

    // reset while streaming burst 2 of a long write
    stall_pct = 20;
    start_cmd(1, 64'h0, 600);
    hit = 0;
    for (int k = 0; k < 20000 && !hit; k++) begin
      @(negedge clk); #1;
      if (ax_q.size() == 2 && w_act && w_idx >= 3) hit = 1;
    end
    chk("reach_burst2", hit, 1);
    #1 rst = 1;
    s0 = sts_cnt;
    @(posedge clk); #1;
    chk("rst_mid_valids", {bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready,
                           bus.m_axi_rready, bus.rdata_valid, bus.wdata_ready, bus.sts_valid}, 0);
    chk("rst_mid_busy", bus.busy, 0);
    @(negedge clk); #2;
    rst = 0;
    repeat (5) @(negedge clk);
    #2 chk("rst_no_sts", sts_cnt, s0);
    stall_pct = 30;
    run_cmd(1, 64'h8000, 40, 0);

    // random commands
    for (int t = 0; t < 14; t++) begin
      bit wr;
      int nb;
      stall_pct = $urandom_range(50);
      wr = 1'($urandom_range(1));
      ra = {$urandom, $urandom} & ~64'hF;
      if ($urandom_range(7) == 0) ra = ra | 64'h4;
      nb = ($urandom_range(5) == 0) ? 0 : $urandom_range(1, 300);
      run_cmd(wr, ra, nb, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
